// File: rtl/approx_pkg.sv
// Shared constants and block-FSM state type for the approximate subtractor stream.
package approx_pkg;
  localparam int WIDTH_DEF = 16;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_ABS  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_REPORT
  } blk_state_t;
endpackage

// File: rtl/approx_diff_stage.sv
// First pipeline stage: registers the (WIDTH+1)-bit a-b (MSB = borrow) and the mode bit.
module approx_diff_stage
  import approx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mode,
  output logic             o_vld,
  output logic [WIDTH:0]   o_diff,
  output logic             o_mode
);
  logic             r_vld;
  logic [WIDTH:0]   r_diff;
  logic             r_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_diff <= '0;
      r_mode <= MODE_WRAP;
    end else if (i_clear) begin
      r_vld  <= 1'b0;
    end else if (i_load) begin
      r_vld  <= 1'b1;
      r_diff <= {1'b0, i_a} - {1'b0, i_b};
      r_mode <= i_mode;
    end else if (i_drain) begin
      r_vld  <= 1'b0;
    end
  end

  assign o_vld  = r_vld;
  assign o_diff = r_diff;
  assign o_mode = r_mode;
endmodule

// File: rtl/approx_subtractor_stream.sv
// Two-stage streaming subtractor with per-block saturating sum of absolute differences.
module approx_subtractor_stream
  import approx_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int BLOCK_LEN = 64,
  parameter int ACC_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             sad_valid,
  output logic [ACC_W-1:0] sad
);
  localparam int CNT_W = (BLOCK_LEN > 2) ? $clog2(BLOCK_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  logic             r_rdy_en;
  logic             w_s1_vld, w_s1_mode, w_s1_move, w_in_xfer, w_out_xfer;
  logic [WIDTH:0]   w_s1_diff;
  logic [WIDTH-1:0] w_low, w_abs;
  logic             w_borrow;

  logic             r_s2_vld, r_borrow;
  logic [WIDTH-1:0] r_diff, r_abs;

  blk_state_t       r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [ACC_W-1:0] r_acc, w_nxt_acc, r_sad, w_nxt_sad, w_sum;
  logic [ACC_W:0]   w_sum_ext;

  assign w_out_xfer = r_s2_vld && out_ready;
  assign w_s1_move  = w_s1_vld && (!r_s2_vld || out_ready);
  assign in_ready   = r_rdy_en && !clear && (!w_s1_vld || w_s1_move);
  assign w_in_xfer  = in_valid && in_ready;

  approx_diff_stage #(.WIDTH(WIDTH)) u_s1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_load  (w_in_xfer),
    .i_drain (w_s1_move),
    .i_a     (in_a),
    .i_b     (in_b),
    .i_mode  (in_mode),
    .o_vld   (w_s1_vld),
    .o_diff  (w_s1_diff),
    .o_mode  (w_s1_mode)
  );

  assign w_borrow = w_s1_diff[WIDTH];
  assign w_low    = w_s1_diff[WIDTH-1:0];
  assign w_abs    = w_borrow ? ({WIDTH{1'b0}} - w_low) : w_low;

  // Holds off in_ready until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdy_en <= 1'b0;
    else        r_rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_abs    <= '0;
    end else if (clear) begin
      r_s2_vld <= 1'b0;
    end else if (w_s1_move) begin
      r_s2_vld <= 1'b1;
      r_diff   <= (w_s1_mode == MODE_ABS) ? w_abs : w_low;
      r_borrow <= w_borrow;
      r_abs    <= w_abs;
    end else if (w_out_xfer) begin
      r_s2_vld <= 1'b0;
    end
  end

  assign out_valid  = r_s2_vld;
  assign out_diff   = r_diff;
  assign out_borrow = r_borrow;

  // Accumulator is already zero in REPORT, so the same sum starts the next block.
  assign w_sum_ext = {1'b0, r_acc} + {{(ACC_W + 1 - WIDTH){1'b0}}, r_abs};
  assign w_sum     = w_sum_ext[ACC_W] ? {ACC_W{1'b1}} : w_sum_ext[ACC_W-1:0];

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_acc   = r_acc;
    w_nxt_sad   = r_sad;
    if (r_state == ST_REPORT) w_nxt_state = ST_IDLE;
    if (w_out_xfer) begin
      if (r_cnt == LAST) begin
        w_nxt_sad   = w_sum;
        w_nxt_acc   = '0;
        w_nxt_cnt   = '0;
        w_nxt_state = ST_REPORT;
      end else begin
        w_nxt_acc   = w_sum;
        w_nxt_cnt   = r_cnt + CNT_W'(1);
        w_nxt_state = ST_ACCUM;
      end
    end
    if (clear) begin
      w_nxt_state = ST_IDLE;
      w_nxt_cnt   = '0;
      w_nxt_acc   = '0;
      w_nxt_sad   = r_sad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sad   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_acc   <= w_nxt_acc;
      r_sad   <= w_nxt_sad;
    end
  end

  assign sad_valid = (r_state == ST_REPORT);
  assign sad       = r_sad;
endmodule

// File: tb/tb_approx_subtractor_stream.sv
// Directed bench for approx_subtractor_stream with BLOCK_LEN=4.
module tb_approx_subtractor_stream;
  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, in_ready, in_mode;
  logic [15:0] in_a, in_b, out_diff;
  logic        out_valid, out_ready, out_borrow, sad_valid;
  logic [31:0] sad;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] got_d[$];
  logic        got_b[$];
  int          n_sad = 0;
  logic [31:0] last_sad = '0;

  localparam int NEXP = 14;
  localparam logic [15:0] EXP_D [NEXP] = '{16'h0001, 16'hFFF6, 16'h000A,
                                          16'h0001, 16'hFFF6, 16'h0001, 16'h0000,
                                          16'h0001, 16'h0032, 16'hFFFC,
                                          16'h0002, 16'h0002, 16'h000A, 16'hFFF6};
  localparam logic EXP_B [NEXP] = '{1'b0, 1'b1, 1'b1,
                                    1'b0, 1'b1, 1'b1, 1'b0,
                                    1'b1, 1'b0, 1'b1,
                                    1'b0, 1'b1, 1'b0, 1'b1};

  approx_subtractor_stream #(.WIDTH(16), .BLOCK_LEN(4), .ACC_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_diff   (out_diff),
    .out_borrow (out_borrow),
    .sad_valid  (sad_valid),
    .sad        (sad)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so values seen at negedge are what the next edge uses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        got_d.push_back(out_diff);
        got_b.push_back(out_borrow);
      end
      if (sad_valid) begin
        n_sad++;
        last_sad = sad;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic m);
    bit done = 0;
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stable_bad, have_snap, saw_drop;
    logic [15:0] snap;
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_mode = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_diff", out_diff, 0);
    chk("rst_out_borrow", out_borrow, 0);
    chk("rst_sad_valid", sad_valid, 0);
    chk("rst_sad", sad, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rdy_before_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("rdy_after_edge", in_ready, 1);

    // latency of a single pair
    send(16'd16, 16'd15, 1'b0);
    in_valid = 1'b0;
    chk("lat_cycle1_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_cycle2_valid", out_valid, 1);
    chk("lat_diff", out_diff, 16'd1);
    chk("lat_borrow", out_borrow, 0);

    send(16'd11, 16'd21, 1'b0);
    send(16'd11, 16'd21, 1'b1);
    in_valid = 1'b0;
    cycles(4);
    chk("partial_xfers", got_d.size(), 3);

    // reset mid-block: partial SAD must vanish
    rst_n = 1'b0;
    cycles(2);
    chk("midrst_sad", sad, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_pulse", n_sad, 0);

    send(16'd16, 16'd15, 1'b0);
    send(16'd11, 16'd21, 1'b0);
    send(16'd0, 16'd65535, 1'b0);
    send(16'd7, 16'd7, 1'b0);
    in_valid = 1'b0;
    cycles(6);
    chk("blk1_pulses", n_sad, 1);
    chk("blk1_sad", last_sad, 32'd65546);
    chk("blk1_sad_held", sad, 32'd65546);

    // backpressure: 3 pairs while out_ready is low for 5 cycles
    out_ready = 1'b0;
    stable_bad = 0; have_snap = 0; saw_drop = 0; snap = '0;
    fork
      begin
        send(16'd1, 16'd2, 1'b1);
        send(16'd100, 16'd50, 1'b0);
        send(16'd5, 16'd9, 1'b0);
        in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          if (!in_ready) saw_drop = 1;
          if (out_valid) begin
            if (have_snap == 0) begin have_snap = 1; snap = out_diff; end
            else if (out_diff != snap) stable_bad++;
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    cycles(6);
    chk("stall_rdy_drop", saw_drop, 1);
    chk("stall_held_valid", have_snap, 1);
    chk("stall_snap", snap, 16'd1);
    chk("stall_stable", stable_bad, 0);
    chk("stall_xfers", got_d.size(), 10);

    // clear with S2 full and a pair offered
    out_ready = 1'b0;
    send(16'd20, 16'd3, 1'b0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("clr_s2_full", out_valid, 1);
    in_a = 16'd9; in_b = 16'd4; in_mode = 1'b0; in_valid = 1'b1; clear = 1'b1;
    @(negedge clk);
    chk("clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_sad_kept", sad, 32'd65546);
    out_ready = 1'b1;
    cycles(4);
    chk("clr_no_xfer", got_d.size(), 10);

    // block after clear starts from zero count
    send(16'd3, 16'd1, 1'b0);
    send(16'd1, 16'd3, 1'b1);
    send(16'd10, 16'd0, 1'b0);
    send(16'd0, 16'd10, 1'b0);
    in_valid = 1'b0;
    cycles(6);
    chk("blk2_pulses", n_sad, 2);
    chk("blk2_sad", last_sad, 32'd24);

    chk("total_xfers", got_d.size(), NEXP);
    for (int i = 0; i < NEXP && i < got_d.size(); i++) begin
      chk($sformatf("xfer%0d_diff", i), got_d[i], EXP_D[i]);
      chk($sformatf("xfer%0d_borrow", i), got_b[i], EXP_B[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
